ts_ci_arbiter: RTL

TS_CI_ARBITER -- requirements
Module: ts_ci_arbiter

---
 rtl/ts_ci_pkg.sv | 23 ++
 rtl/ts_ci_rr_arb.sv | 19 +
 rtl/ts_ci_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ts_ci_pkg.sv
// Shared definitions for the TS-to-CI input arbiter: packet geometry,
// FSM encoding and saturating counter helpers.
package ts_ci_pkg;

  localparam int unsigned TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } ts_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, v} + {7'd0, inc};
    return s[8] ? '1 : s[7:0];
  endfunction

endpackage

// File: rtl/ts_ci_rr_arb.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// source that did not own the path last.
module ts_ci_rr_arb (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/ts_ci_arbiter.sv
// Packet-level arbiter merging two TS byte streams into the CI input FIFO,
// with sync hunting, abort on premature restart and per-source statistics.
module ts_ci_arbiter
  import ts_ci_pkg::*;
#(
  parameter int unsigned PKT_LEN   = TS_PKT_LEN,
  parameter logic [7:0]  SYNC_BYTE = TS_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  src0_d,
  input  logic        src0_valid,
  input  logic        src0_start,
  output logic        src0_ready,
  input  logic [7:0]  src1_d,
  input  logic        src1_valid,
  input  logic        src1_start,
  output logic        src1_ready,
  input  logic [1:0]  enable,
  output logic [7:0]  ts_ci_in_d,
  output logic        ts_ci_wrreq,
  input  logic        ts_ci_almost_full,
  output logic [1:0]  grant,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);

  ts_state_t  state;
  logic       last;
  logic [7:0] count;

  logic [1:0] valid, start, sync, req, gnt, ready, bad_start;
  logic       owner, own_valid, own_start, restart, accept, abort;
  logic [7:0] own_d;
  logic [1:0] err_inc;

  assign valid = {src1_valid, src0_valid};
  assign start = {src1_start, src0_start};
  assign sync  = {src1_d == SYNC_BYTE, src0_d == SYNC_BYTE};
  assign req   = enable & valid & start & sync;

  // grant is only non-zero in XFER, so its upper bit names the owner there
  assign owner     = grant[1];
  assign own_valid = owner ? src1_valid : src0_valid;
  assign own_start = owner ? src1_start : src0_start;
  assign own_d     = owner ? src1_d     : src0_d;
  assign restart   = own_valid & own_start & (count != '0);

  ts_ci_rr_arb u_rr (
    .req  (req),
    .last (last),
    .gnt  (gnt)
  );

  // Requesters hold their sync byte in IDLE; it is consumed as byte 0 in XFER.
  // The owner keeps the path even if its enable drops mid-packet.
  always_comb begin
    ready     = '0;
    bad_start = '0;
    accept    = 1'b0;
    abort     = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        ready     = ~req;
        bad_start = enable & valid & start & ~sync;
      end else begin
        ready        = ~enable;
        ready[owner] = ~ts_ci_almost_full & ~restart;
        accept       = own_valid & ready[owner];
        abort        = restart;
      end
    end
  end

  assign src0_ready = ready[0];
  assign src1_ready = ready[1];
  assign err_inc    = {1'b0, bad_start[0]} + {1'b0, bad_start[1]} + {1'b0, abort};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      count       <= '0;
      grant       <= '0;
      ts_ci_wrreq <= 1'b0;
      ts_ci_in_d  <= '0;
      pkt_cnt0    <= '0;
      pkt_cnt1    <= '0;
      err_cnt     <= '0;
    end else begin
      ts_ci_wrreq <= accept;
      if (accept) ts_ci_in_d <= own_d;
      err_cnt <= sat_add8(err_cnt, err_inc);

      case (state)
        IDLE: begin
          if (!ts_ci_almost_full && (gnt != '0)) begin
            state <= XFER;
            grant <= gnt;
            count <= '0;
          end
        end
        XFER: begin
          if (abort) begin
            state <= IDLE;
            grant <= '0;
            last  <= owner;
            count <= '0;
          end else if (accept) begin
            if (count == LAST_IDX) begin
              state <= IDLE;
              grant <= '0;
              last  <= owner;
              count <= '0;
              if (owner) pkt_cnt1 <= sat_inc16(pkt_cnt1);
              else       pkt_cnt0 <= sat_inc16(pkt_cnt0);
            end else begin
              count <= count + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
